// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared bus widths and FSM state type for mem_responder
package mem_responder_pkg;

    localparam int ADLINES   = 8;
    localparam int DATALINES = 16;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_store.sv
// rtl/mem_store.sv - word array with synchronous write and registered read
module mem_store #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_en,
    input  logic              rd_zero,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Array contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= rd_zero ? '0 : mem[raddr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - CU memory responder with wait cycles and four-phase ready handshake
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W      = ADLINES,
    parameter int DATA_W      = DATALINES,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] datain,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] dataout,
    output logic              ready,
    output logic              err,
    output logic              busy,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]    DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0]   WAIT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  cap_addr;
    logic [DATA_W-1:0]  cap_data;
    logic               cap_write;
    logic               cap_en;
    logic               in_range;
    logic               load_ok;
    logic               ready_d, err_d;
    logic               we, rd_en;
    logic [IDX_W-1:0]   waddr;
    logic [DATA_W-1:0]  wdata;

    assign in_range = {1'b0, cap_addr}  < DEPTH_L;
    assign load_ok  = {1'b0, load_addr} < DEPTH_L;
    assign cap_en   = (state == ST_IDLE) && !load_en && (read ^ write);
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ready <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_d;
            ready <= ready_d;
            err   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            cap_addr  <= '0;
            cap_data  <= '0;
            cap_write <= 1'b0;
        end else if (cap_en) begin
            cnt       <= '0;
            cap_addr  <= address;
            cap_data  <= datain;
            cap_write <= write;
        end else if (state == ST_WAIT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Preload owns the write port in IDLE; ACCESS uses it for CU writes.
    always_comb begin
        state_d = state;
        ready_d = 1'b0;
        err_d   = 1'b0;
        we      = 1'b0;
        rd_en   = 1'b0;
        waddr   = load_addr[IDX_W-1:0];
        wdata   = load_data;
        case (state)
            ST_IDLE: begin
                if (load_en) begin
                    we = load_ok;
                end else if (read && write) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (read || write) begin
                    state_d = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == WAIT_LAST) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                ready_d = 1'b1;
                err_d   = !in_range;
                state_d = ST_DONE;
                if (cap_write) begin
                    we    = in_range;
                    waddr = cap_addr[IDX_W-1:0];
                    wdata = cap_data;
                end else begin
                    rd_en = 1'b1;
                end
            end
            ST_DONE: begin
                if (!read && !write) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    mem_store #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_store (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .rd_en   (rd_en),
        .rd_zero (!in_range),
        .raddr   (cap_addr[IDX_W-1:0]),
        .rdata   (dataout)
    );

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  address;
    logic [15:0] datain;
    logic        read, write;
    logic [15:0] dataout;
    logic        ready, err, busy;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [15:0] load_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_responder #(
        .ADDR_W      (8),
        .DATA_W      (16),
        .DEPTH       (64),
        .WAIT_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .address   (address),
        .datain    (datain),
        .read      (read),
        .write     (write),
        .dataout   (dataout),
        .ready     (ready),
        .err       (err),
        .busy      (busy),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    // Drives a request and waits (bounded) for the first ready/err edge.
    // lat counts posedges from the drive point, so the capture edge is 1.
    task automatic cu_req(input logic r, input logic w, input logic [7:0] a,
                          input logic [15:0] d, output int lat,
                          output logic rdy, output logic er);
        read = r; write = w; address = a; datain = d;
        lat = 0; rdy = 1'b0; er = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ready || err) begin
                lat = i; rdy = ready; er = err;
                break;
            end
        end
    endtask

    task automatic cu_release();
        read = 1'b0; write = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++; if (dataout !== 16'h0 || ready !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_outputs: dataout=%h ready=%b err=%b busy=%b, required 0/0/0/0", dataout, ready, err, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_preload_read();
        int lat; logic rdy, er;
        preload(8'd3, 16'h00A5);
        cu_req(1'b1, 1'b0, 8'd3, 16'h0, lat, rdy, er);
        total++; if (lat !== 4 || rdy !== 1'b1 || er !== 1'b0) begin
            bad++; $display("FAIL read_latency: lat=%0d ready=%b err=%b, required lat=4 ready=1 err=0", lat, rdy, er);
        end
        total++; if (dataout !== 16'h00A5) begin
            bad++; $display("FAIL read_data: dataout=%h, required 00a5", dataout);
        end
        cu_release();
        total++; if (busy !== 1'b0) begin
            bad++; $display("FAIL read_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid_wait();
        int lat; logic rdy, er;
        preload(8'd9, 16'h1111);
        read = 1'b0; write = 1'b1; address = 8'd9; datain = 16'hBEEF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if (busy !== 1'b1) begin
            bad++; $display("FAIL wait_busy: busy=%b, required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        total++; if (dataout !== 16'h0 || ready !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL async_reset: dataout=%h ready=%b busy=%b, required 0/0/0", dataout, ready, busy);
        end
        write = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_release_idle: busy=%b, required 0", busy);
        end
        cu_req(1'b1, 1'b0, 8'd9, 16'h0, lat, rdy, er);
        total++; if (dataout !== 16'h1111 || rdy !== 1'b1) begin
            bad++; $display("FAIL aborted_write: dataout=%h ready=%b, required 1111 ready=1", dataout, rdy);
        end
        cu_release();
    endtask

    task automatic test_write_read();
        int lat; logic rdy, er;
        cu_req(1'b0, 1'b1, 8'd16, 16'h1234, lat, rdy, er);
        total++; if (lat !== 4 || rdy !== 1'b1 || er !== 1'b0) begin
            bad++; $display("FAIL write_latency: lat=%0d ready=%b err=%b, required lat=4 ready=1 err=0", lat, rdy, er);
        end
        @(posedge clk); #1;
        total++; if (ready !== 1'b0) begin
            bad++; $display("FAIL write_single_pulse: ready=%b, required 0", ready);
        end
        cu_release();
        cu_req(1'b1, 1'b0, 8'd16, 16'h0, lat, rdy, er);
        total++; if (dataout !== 16'h1234 || lat !== 4 || rdy !== 1'b1) begin
            bad++; $display("FAIL write_readback: dataout=%h lat=%0d, required 1234 lat=4", dataout, lat);
        end
        @(posedge clk); #1;
        total++; if (ready !== 1'b0) begin
            bad++; $display("FAIL read_single_pulse: ready=%b, required 0", ready);
        end
        cu_release();
    endtask

    task automatic test_hold();
        int lat; logic rdy, er;
        int extra;
        int idle_seen;
        cu_req(1'b1, 1'b0, 8'd3, 16'h0, lat, rdy, er);
        extra = 0; idle_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ready) extra++;
            if (!busy) idle_seen++;
        end
        total++; if (extra !== 0) begin
            bad++; $display("FAIL hold_no_second_ready: extra=%0d, required 0", extra);
        end
        total++; if (idle_seen !== 0) begin
            bad++; $display("FAIL hold_busy: idle_cycles=%0d, required 0", idle_seen);
        end
        cu_release();
        total++; if (busy !== 1'b0) begin
            bad++; $display("FAIL hold_release_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_both();
        int lat; logic rdy, er;
        preload(8'd20, 16'hCAFE);
        cu_req(1'b1, 1'b1, 8'd20, 16'hDEAD, lat, rdy, er);
        total++; if (lat !== 1 || er !== 1'b1 || rdy !== 1'b0) begin
            bad++; $display("FAIL both_err: lat=%0d err=%b ready=%b, required lat=1 err=1 ready=0", lat, er, rdy);
        end
        @(posedge clk); #1;
        total++; if (err !== 1'b0 || ready !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL both_after: err=%b ready=%b busy=%b, required 0/0/1", err, ready, busy);
        end
        cu_release();
        cu_req(1'b1, 1'b0, 8'd20, 16'h0, lat, rdy, er);
        total++; if (dataout !== 16'hCAFE) begin
            bad++; $display("FAIL both_mem_unchanged: dataout=%h, required cafe", dataout);
        end
        cu_release();
    endtask

    task automatic test_load_and_read();
        int lat; logic rdy, er;
        load_en = 1'b1; load_addr = 8'd5; load_data = 16'h0007;
        read = 1'b1; address = 8'd5;
        @(posedge clk); #1;
        load_en = 1'b0;
        total++; if (busy !== 1'b0) begin
            bad++; $display("FAIL load_priority_idle: busy=%b, required 0", busy);
        end
        cu_req(1'b1, 1'b0, 8'd5, 16'h0, lat, rdy, er);
        total++; if (dataout !== 16'h0007 || lat !== 4 || rdy !== 1'b1) begin
            bad++; $display("FAIL load_then_read: dataout=%h lat=%0d, required 0007 lat=4", dataout, lat);
        end
        cu_release();
    endtask

    task automatic test_out_of_range();
        int lat; logic rdy, er;
        preload(8'd8, 16'h0808);
        cu_req(1'b1, 1'b0, 8'd200, 16'h0, lat, rdy, er);
        total++; if (lat !== 4 || rdy !== 1'b1 || er !== 1'b1) begin
            bad++; $display("FAIL oor_read_flags: lat=%0d ready=%b err=%b, required lat=4 ready=1 err=1", lat, rdy, er);
        end
        total++; if (dataout !== 16'h0) begin
            bad++; $display("FAIL oor_read_data: dataout=%h, required 0000", dataout);
        end
        cu_release();
        cu_req(1'b0, 1'b1, 8'd72, 16'h5555, lat, rdy, er);
        total++; if (rdy !== 1'b1 || er !== 1'b1) begin
            bad++; $display("FAIL oor_write_flags: ready=%b err=%b, required 1/1", rdy, er);
        end
        cu_release();
        cu_req(1'b1, 1'b0, 8'd8, 16'h0, lat, rdy, er);
        total++; if (dataout !== 16'h0808 || er !== 1'b0) begin
            bad++; $display("FAIL oor_write_dropped: dataout=%h err=%b, required 0808 err=0", dataout, er);
        end
        cu_release();
        cu_req(1'b1, 1'b0, 8'd63, 16'h0, lat, rdy, er);
        total++; if (er !== 1'b0 || rdy !== 1'b1) begin
            bad++; $display("FAIL last_word_in_range: err=%b ready=%b, required 0/1", er, rdy);
        end
        cu_release();
    endtask

    task automatic test_load_outside_idle();
        int lat; logic rdy, er;
        preload(8'd30, 16'h3030);
        read = 1'b1; write = 1'b0; address = 8'd30;
        @(posedge clk); #1;
        load_en = 1'b1; load_addr = 8'd30; load_data = 16'hFFFF;
        @(posedge clk); #1;
        load_en = 1'b0;
        for (int i = 0; i < 20 && !ready; i++) begin
            @(posedge clk); #1;
        end
        cu_release();
        cu_req(1'b1, 1'b0, 8'd30, 16'h0, lat, rdy, er);
        total++; if (dataout !== 16'h3030) begin
            bad++; $display("FAIL load_ignored_busy: dataout=%h, required 3030", dataout);
        end
        cu_release();
    endtask

    initial begin
        rst_n = 1'b0;
        address = '0; datain = '0; read = 1'b0; write = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        test_reset();
        test_preload_read();
        test_reset_mid_wait();
        test_write_read();
        test_hold();
        test_both();
        test_load_and_read();
        test_out_of_range();
        test_load_outside_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
